// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit controller.
// Macro UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

    localparam logic [7:0] UART_DATA_ADDR = 8'h00;
    localparam logic [7:0] UART_CSR_ADDR  = 8'h04;

    localparam int CSR_BUSY_BIT   = 0;
    localparam int CSR_FULL_BIT   = 1;
    localparam int CSR_EMPTY_BIT  = 2;
    localparam int CSR_OVF_BIT    = 3;
    localparam int CSR_IRQ_EN_BIT = 4;
    localparam int CSR_PARITY_BIT = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } uart_tx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop in the same cycle lets a push into a full FIFO succeed.
// full/empty are flops updated from the next-state occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop_i & ~empty_q;
    assign push_ok = push_i & (~full_q | pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: contents are only visible through valid entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a register interface (DATA/CSR), TX FIFO and level irq.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | start bit (tx=0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (tx=1), then next byte or IDLE
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_we,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic [31:0] io_uart_io_reg,
    output logic [31:0] io_uart_csr_reg,
    output logic        tx,
    output logic        irq
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     data_q, data_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;
    logic           irq_en_q, irq_en_d;
    logic [7:0]     io_reg_q, io_reg_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;
    logic       wr_data, wr_csr, push_ok, baud_done;
    logic       unused_wdata;

    assign unused_wdata = ^io_wdata[31:8];

    assign wr_data   = io_we & (io_addr == UART_DATA_ADDR);
    assign wr_csr    = io_we & (io_addr == UART_CSR_ADDR);
    assign push_ok   = wr_data & (~fifo_full | fifo_pop);
    assign baud_done = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (wr_data),
        .pop_i   (fifo_pop),
        .wdata_i (io_wdata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 16'd1;
        bit_d    = bit_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = data_q[bit_q];
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = even_parity(data_q);
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_rdata;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ovf_d    = (ovf_q & ~(wr_csr & io_wdata[CSR_OVF_BIT]))
                 | (wr_data & fifo_full & ~fifo_pop);
        irq_en_d = wr_csr ? io_wdata[CSR_IRQ_EN_BIT] : irq_en_q;
        io_reg_d = push_ok ? io_wdata[7:0] : io_reg_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            io_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            io_reg_q <= io_reg_d;
        end
    end

    always_comb begin
        io_uart_csr_reg                 = '0;
        io_uart_csr_reg[CSR_BUSY_BIT]   = (state_q != ST_IDLE);
        io_uart_csr_reg[CSR_FULL_BIT]   = fifo_full;
        io_uart_csr_reg[CSR_EMPTY_BIT]  = fifo_empty;
        io_uart_csr_reg[CSR_OVF_BIT]    = ovf_q;
        io_uart_csr_reg[CSR_IRQ_EN_BIT] = irq_en_q;
`ifdef UART_TX_PARITY_EN
        io_uart_csr_reg[CSR_PARITY_BIT] = 1'b1;
`endif
    end

    assign io_uart_io_reg = {24'b0, io_reg_q};

    always_comb begin
        case (io_addr)
            UART_DATA_ADDR: io_rdata = io_uart_io_reg;
            UART_CSR_ADDR:  io_rdata = io_uart_csr_reg;
            default:        io_rdata = '0;
        endcase
    end

    assign tx  = tx_q;
    assign irq = irq_en_q & fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: register table plus serial-frame sequences.
module tb_uart_tx_ctrl;

    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PAR = 32'h20;
`else
    localparam logic [31:0] PAR = 32'h00;
`endif

    logic        clk, rst_n, io_we, tx, irq;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata, io_rdata, io_uart_io_reg, io_uart_csr_reg;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_wr[$];
    logic [7:0] q_exp[$];
    logic       irq_en_m;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[8];

    uart_tx_ctrl #(.CLK_DIV(CD), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst_n),
        .io_we           (io_we),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .io_rdata        (io_rdata),
        .io_uart_io_reg  (io_uart_io_reg),
        .io_uart_csr_reg (io_uart_csr_reg),
        .tx              (tx),
        .irq             (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic csr_write(input logic [31:0] val);
        io_we = 1'b1; io_addr = 8'h04; io_wdata = val;
        @(posedge clk); #1;
        io_we = 1'b0; io_addr = 8'h00; io_wdata = '0;
    endtask

    // Writes q_wr on consecutive cycles (first write edge = E0) and checks the
    // line cycle-by-cycle against the frames of q_exp sent back to back.
    task automatic send_check();
        logic bits[$];
        int   nbits, kmax, idx;
        logic exp_tx, exp_busy;
        bits = {};
        foreach (q_exp[f]) begin
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(q_exp[f][i]);
`ifdef UART_TX_PARITY_EN
            bits.push_back(^q_exp[f]);
`endif
            bits.push_back(1'b1);
        end
        nbits = bits.size();
        kmax  = 2 + nbits * CD + 2;
        io_we = 1'b1; io_addr = 8'h00; io_wdata = {24'h0, q_wr[0]};
        for (int k = 0; k <= kmax; k++) begin
            @(posedge clk); #1;
            if (k + 1 < q_wr.size()) begin
                io_we = 1'b1; io_wdata = {24'h0, q_wr[k+1]};
            end else begin
                io_we = 1'b0; io_wdata = '0;
            end
            idx      = (k - 2) / CD;
            exp_tx   = (k < 2 || idx >= nbits) ? 1'b1 : bits[idx];
            exp_busy = (k >= 1) && (k <= nbits * CD);
            chk($sformatf("tx k=%0d", k), {31'b0, tx}, {31'b0, exp_tx});
            chk($sformatf("busy k=%0d", k), {31'b0, io_uart_csr_reg[0]}, {31'b0, exp_busy});
            chk($sformatf("irq k=%0d", k), {31'b0, irq},
                {31'b0, irq_en_m & (k >= 1) & ~exp_busy});
            if (k == q_wr.size() - 1) begin
                chk("ovf after writes", {31'b0, io_uart_csr_reg[3]},
                    {31'b0, q_wr.size() > q_exp.size()});
                chk("full after writes", {31'b0, io_uart_csr_reg[1]},
                    {31'b0, q_wr.size() > q_exp.size()});
            end
        end
        chk("io_reg last accepted", io_uart_io_reg, {24'h0, q_exp[q_exp.size()-1]});
        chk("csr idle empty", io_uart_csr_reg & 32'h7, 32'h4);
    endtask

    initial begin
        rst_n = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0; irq_en_m = 1'b0;

        vecs[0] = '{1'b1, 8'h04, 32'h0000_0010, 8'h04, 32'h14 | PAR, 1'b1};
        vecs[1] = '{1'b1, 8'h08, 32'hFFFF_FFFF, 8'h04, 32'h14 | PAR, 1'b1};
        vecs[2] = '{1'b1, 8'h0C, 32'h0000_00AB, 8'h00, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 8'h00, 32'h0,         8'h08, 32'h0,        1'b1};
        vecs[4] = '{1'b1, 8'h04, 32'hFFFF_FFEF, 8'h04, 32'h04 | PAR, 1'b0};
        vecs[5] = '{1'b1, 8'h04, 32'h0000_0010, 8'h00, 32'h0,        1'b1};
        vecs[6] = '{1'b1, 8'h04, 32'h0000_0000, 8'h04, 32'h04 | PAR, 1'b0};
        vecs[7] = '{1'b1, 8'h05, 32'h0000_0010, 8'h04, 32'h04 | PAR, 1'b0};

        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset csr", io_uart_csr_reg, 32'h4 | PAR);
        chk("reset tx", {31'b0, tx}, 32'h1);
        chk("reset irq", {31'b0, irq}, 32'h0);
        chk("reset io_reg", io_uart_io_reg, 32'h0);
        io_addr = 8'h04; #1;
        chk("reset rdata csr", io_rdata, 32'h4 | PAR);
        io_addr = 8'h00;

        for (int i = 0; i < 8; i++) begin
            io_we = vecs[i].we; io_addr = vecs[i].addr; io_wdata = vecs[i].wdata;
            @(posedge clk); #1;
            io_we = 1'b0; io_addr = vecs[i].raddr; io_wdata = '0;
            #1;
            chk($sformatf("vec%0d rdata", i), io_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end

        // single byte
        q_wr = {}; q_exp = {};
        q_wr.push_back(8'h55); q_exp.push_back(8'h55);
        send_check();

        // back to back
        q_wr = {}; q_exp = {};
        q_wr.push_back(8'hA5); q_wr.push_back(8'h3C);
        q_exp.push_back(8'hA5); q_exp.push_back(8'h3C);
        send_check();

        // overflow: first pop frees a slot, sixth write dropped
        q_wr = {}; q_exp = {};
        for (int i = 0; i < 6; i++) q_wr.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) q_exp.push_back(8'h10 + 8'(i));
        send_check();
        chk("ovf sticky", {31'b0, io_uart_csr_reg[3]}, 32'h1);
        csr_write(32'h08);
        chk("ovf cleared", {31'b0, io_uart_csr_reg[3]}, 32'h0);

        // interrupt
        csr_write(32'h10);
        irq_en_m = 1'b1;
        chk("irq idle enabled", {31'b0, irq}, 32'h1);
        q_wr = {}; q_exp = {};
        q_wr.push_back(8'hFF); q_exp.push_back(8'hFF);
        send_check();

`ifdef UART_TX_PARITY_EN
        q_wr = {}; q_exp = {};
        q_wr.push_back(8'h07); q_exp.push_back(8'h07);
        send_check();
        q_wr = {}; q_exp = {};
        q_wr.push_back(8'h03); q_exp.push_back(8'h03);
        send_check();
`endif

        // reset during data bit 3 of 0x55
        io_we = 1'b1; io_addr = 8'h00; io_wdata = 32'h55;
        @(posedge clk); #1;
        io_we = 1'b0; io_wdata = '0;
        repeat (19) @(posedge clk);
        #1;
        chk("mid-frame bit3", {31'b0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset tx", {31'b0, tx}, 32'h1);
        chk("async reset csr", io_uart_csr_reg, 32'h4 | PAR);
        chk("async reset irq", {31'b0, irq}, 32'h0);
        chk("async reset io_reg", io_uart_io_reg, 32'h0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset tx k=%0d", k), {31'b0, tx}, 32'h1);
        end
        chk("post-reset csr", io_uart_csr_reg, 32'h4 | PAR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
